// File: rtl/seq_alu_v2_if.sv
// Handshaked operand/result bundle between the register-file read stage and the sequential ALU.
`timescale 1ns/1ps
interface seq_alu_v2_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             cout;
  logic             illegal;

  modport master (
    output in_valid, opcode, x, y, out_ready,
    input  in_ready, out_valid, r, negative, zero, overflow, cout, illegal
  );

  modport slave (
    input  in_valid, opcode, x, y, out_ready,
    output in_ready, out_valid, r, negative, zero, overflow, cout, illegal
  );
endinterface

// File: rtl/seq_alu_v2.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus 1-bit/cycle multiply and restoring divide,
// with registered result/flags and valid/ready handshakes on both sides.
`timescale 1ns/1ps
module seq_alu_v2 #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  seq_alu_v2_if.slave  alu
);
  localparam int W    = WIDTH;
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [W-1:0]     W_LIM = W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  localparam logic [4:0] OP_PASS  = 5'b00000, OP_ADD   = 5'b00001, OP_SUB   = 5'b00010,
                         OP_MULHS = 5'b00011, OP_MULHU = 5'b00100, OP_CMP   = 5'b00101,
                         OP_AND   = 5'b00110, OP_OR    = 5'b00111, OP_NOR   = 5'b01000,
                         OP_NAND  = 5'b01001, OP_XOR   = 5'b01010, OP_XNOR  = 5'b01011,
                         OP_NOT   = 5'b01100, OP_UDIV  = 5'b01101, OP_UREM  = 5'b01110,
                         OP_MULLS = 5'b01111, OP_MULLU = 5'b10000, OP_LSR   = 5'b11000,
                         OP_LSL   = 5'b11001, OP_ASR   = 5'b11010, OP_ROR   = 5'b11100;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [W-1:0]     r_q, r_d;
  logic             n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d, ill_q, ill_d;

  // Single-cycle datapath, evaluated directly on the accept-cycle inputs
  logic [W:0]          add_w, sub_w;
  logic [W:0]          shl_w, shr_w;
  logic signed [W:0]   sar_w;
  logic [W-1:0]        ror_w;
  logic [CNT_W-1:0]    sh_amt;
  logic [SH_W-1:0]     rot_amt;
  logic                y_gt, y_zero;
  logic [W-1:0]        s_r;
  logic                s_n, s_z, s_v, s_c, s_ill, s_multi;
  logic                sgn_in;
  logic [W-1:0]        x_mag, y_mag;

  assign add_w   = {1'b0, alu.x} + {1'b0, alu.y};
  assign sub_w   = {1'b0, alu.x} - {1'b0, alu.y};
  assign y_gt    = alu.y > W_LIM;
  assign y_zero  = alu.y == '0;
  // Amounts beyond W behave like W, except that only zeros/sign bits leave in that case
  assign sh_amt  = y_gt ? CNT_W'(WIDTH) : alu.y[CNT_W-1:0];
  assign shl_w   = {1'b0, alu.x} << sh_amt;
  assign shr_w   = {alu.x, 1'b0} >> sh_amt;
  assign sar_w   = $signed({alu.x, 1'b0}) >>> sh_amt;
  assign rot_amt = alu.y[SH_W-1:0];
  assign ror_w   = (alu.x >> rot_amt) | (alu.x << (WIDTH - int'(rot_amt)));
  assign sgn_in  = (alu.opcode == OP_MULHS) || (alu.opcode == OP_MULLS);
  assign x_mag   = (sgn_in && alu.x[W-1]) ? -alu.x : alu.x;
  assign y_mag   = (sgn_in && alu.y[W-1]) ? -alu.y : alu.y;

  always_comb begin
    s_r     = '0;
    s_v     = 1'b0;
    s_c     = 1'b0;
    s_ill   = 1'b0;
    s_multi = 1'b0;
    unique case (alu.opcode)
      OP_PASS: s_r = alu.x;
      OP_ADD: begin
        s_r = add_w[W-1:0];
        s_c = add_w[W];
        s_v = (alu.x[W-1] == alu.y[W-1]) && (add_w[W-1] != alu.x[W-1]);
      end
      OP_SUB, OP_CMP: begin
        s_r = sub_w[W-1:0];
        s_c = ~sub_w[W];
        s_v = (alu.x[W-1] != alu.y[W-1]) && (sub_w[W-1] != alu.x[W-1]);
      end
      OP_AND:  s_r = alu.x & alu.y;
      OP_OR:   s_r = alu.x | alu.y;
      OP_NOR:  s_r = ~(alu.x | alu.y);
      OP_NAND: s_r = ~(alu.x & alu.y);
      OP_XOR:  s_r = alu.x ^ alu.y;
      OP_XNOR: s_r = ~(alu.x ^ alu.y);
      OP_NOT:  s_r = ~alu.x;
      OP_MULHS, OP_MULHU, OP_MULLS, OP_MULLU, OP_UDIV, OP_UREM: s_multi = 1'b1;
      OP_LSL: begin
        s_r = shl_w[W-1:0];
        s_c = y_gt ? 1'b0 : shl_w[W];
      end
      OP_LSR: begin
        s_r = shr_w[W:1];
        s_c = y_gt ? 1'b0 : shr_w[0];
      end
      OP_ASR: begin
        s_r = sar_w[W:1];
        s_c = sar_w[0];
      end
      OP_ROR: begin
        s_r = ror_w;
        s_c = y_zero ? 1'b0 : ror_w[W-1];
      end
      default: s_ill = 1'b1;
    endcase
    s_n = s_r[W-1];
    s_z = (s_r == '0);
    // cmp reports the flags of x-y but returns zero
    if (alu.opcode == OP_CMP) s_r = '0;
  end

  // Iterative datapath: shift-add multiply on magnitudes, restoring divide
  logic [2*W-1:0] acc_step, prod;
  logic [W:0]     rem_sh;
  logic           div_ge, is_div, is_hi, is_sgn;
  logic [W-1:0]   rem_nx, quo_nx, fin_r;
  logic           fin_v;

  assign is_div   = (op_q == OP_UDIV) || (op_q == OP_UREM);
  assign is_hi    = (op_q == OP_MULHS) || (op_q == OP_MULHU);
  assign is_sgn   = (op_q == OP_MULHS) || (op_q == OP_MULLS);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod     = neg_q ? -acc_step : acc_step;
  assign rem_sh   = {acc_q[W-1:0], mcand_q[W-1]};
  assign div_ge   = rem_sh >= {1'b0, mplier_q};
  assign rem_nx   = div_ge ? W'(rem_sh - {1'b0, mplier_q}) : rem_sh[W-1:0];
  assign quo_nx   = {mcand_q[W-2:0], div_ge};

  always_comb begin
    fin_r = is_hi ? prod[2*W-1:W] : prod[W-1:0];
    fin_v = is_sgn ? (prod[2*W-1:W] != {W{prod[W-1]}}) : (prod[2*W-1:W] != '0);
    if (op_q == OP_UDIV) begin
      fin_r = quo_nx;
      fin_v = (mplier_q == '0);
    end else if (op_q == OP_UREM) begin
      fin_r = rem_nx;
      fin_v = (mplier_q == '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    r_d      = r_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    c_d      = c_q;
    ill_d    = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (alu.in_valid) begin
          op_d = alu.opcode;
          if (s_multi) begin
            state_d  = S_CALC;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, x_mag};
            mplier_d = y_mag;
            neg_d    = sgn_in && (alu.x[W-1] ^ alu.y[W-1]);
          end else begin
            state_d = S_DONE;
            r_d     = s_r;
            n_d     = s_n;
            z_d     = s_z;
            v_d     = s_v;
            c_d     = s_c;
            ill_d   = s_ill;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div) begin
          acc_d   = {{W{1'b0}}, rem_nx};
          mcand_d = {{W{1'b0}}, quo_nx};
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          r_d     = fin_r;
          n_d     = fin_r[W-1];
          z_d     = (fin_r == '0);
          v_d     = fin_v;
          c_d     = 1'b0;
          ill_d   = 1'b0;
        end
      end
      S_DONE: if (alu.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      r_q      <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      r_q      <= r_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
      c_q      <= c_d;
      ill_q    <= ill_d;
    end
  end

  assign alu.in_ready  = (state_q == S_IDLE);
  assign alu.out_valid = (state_q == S_DONE);
  assign alu.r         = r_q;
  assign alu.negative  = n_q;
  assign alu.zero      = z_q;
  assign alu.overflow  = v_q;
  assign alu.cout      = c_q;
  assign alu.illegal   = ill_q;
endmodule

// File: tb/tb_seq_alu_v2.sv
// Scoreboard bench for seq_alu_v2: directed vectors queue expected results, a monitor checks outputs.
`timescale 1ns/1ps
module tb_seq_alu_v2;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_v2_if #(.WIDTH(W)) alu ();
  seq_alu_v2 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .alu(alu));

  typedef struct {
    string      nm;
    logic [15:0] r;
    logic [4:0]  fl;   // {negative, zero, overflow, cout, illegal}
    int          lat;
    int          acc;
    int          stall;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ncyc   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  initial begin : monitor
    exp_t e;
    bit   seen;
    bit   post;
    int   hold;
    seen = 0; post = 0; hold = 0;
    alu.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (post) begin
        post = 0;
        alu.out_ready = 1'b0;
        chk("in_ready after handshake", {31'b0, alu.in_ready}, 32'd1);
        chk("out_valid after handshake", {31'b0, alu.out_valid}, 32'd0);
      end else if (alu.out_valid) begin
        if (!seen) begin
          if (sbq.size() == 0) begin
            chk("unexpected out_valid", {31'b0, alu.out_valid}, 32'd0);
            alu.out_ready = 1'b1;
            continue;
          end
          e    = sbq[0];
          seen = 1;
          hold = e.stall;
          chk({e.nm, " latency"}, ncyc - e.acc, e.lat);
        end
        chk({e.nm, " r"}, {16'b0, alu.r}, {16'b0, e.r});
        chk({e.nm, " flags"}, {27'b0, alu.negative, alu.zero, alu.overflow, alu.cout, alu.illegal},
            {27'b0, e.fl});
        chk({e.nm, " in_ready low"}, {31'b0, alu.in_ready}, 32'd0);
        if (hold > 0) begin
          hold--;
          alu.out_ready = 1'b0;
        end else begin
          alu.out_ready = 1'b1;
          void'(sbq.pop_front());
          seen = 0;
          post = 1;
        end
      end else begin
        alu.out_ready = 1'b0;
      end
    end
  end

  task automatic issue(input string nm, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic [4:0] efl,
                       input int lat, input int stall, input bit push);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk); #1;
    alu.in_valid = 1'b1;
    alu.opcode   = op;
    alu.x        = a;
    alu.y        = b;
    while (!alu.in_ready && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (!alu.in_ready) begin
      chk({nm, " accept timeout"}, {31'b0, alu.in_ready}, 32'd1);
      alu.in_valid = 1'b0;
      return;
    end
    e.nm = nm; e.r = er; e.fl = efl; e.lat = lat; e.acc = ncyc; e.stall = stall;
    if (push) sbq.push_back(e);
    @(negedge clk); #1;
    // Scramble operands after accept; the result must not depend on them
    alu.in_valid = 1'b0;
    alu.opcode   = 5'h1F;
    alu.x        = 16'hDEAD;
    alu.y        = 16'hBEEF;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sbq.size() != 0 || !alu.in_ready) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain queue", sbq.size(), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int seen_v;
    alu.in_valid = 1'b0;
    alu.opcode   = 5'h00;
    alu.x        = 16'h0000;
    alu.y        = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset in_ready", {31'b0, alu.in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, alu.out_valid}, 32'd0);
    chk("reset r", {16'b0, alu.r}, 32'd0);
    chk("reset flags", {27'b0, alu.negative, alu.zero, alu.overflow, alu.cout, alu.illegal}, 32'd0);
    #1 rst = 1'b0;

    //         name           op        x         y         r         NZVCI     lat stall
    issue("add ovf",    5'b00001, 16'h7FFF, 16'h0001, 16'h8000, 5'b10100, 1, 0, 1);
    issue("sub borrow", 5'b00010, 16'h0005, 16'h0007, 16'hFFFE, 5'b10000, 1, 0, 1);
    issue("sub ovf",    5'b00010, 16'h8000, 16'h0001, 16'h7FFF, 5'b00110, 1, 0, 1);
    issue("cmp equal",  5'b00101, 16'h1234, 16'h1234, 16'h0000, 5'b01010, 1, 0, 1);
    issue("pass",       5'b00000, 16'h8000, 16'h1111, 16'h8000, 5'b10000, 1, 0, 1);
    issue("and",        5'b00110, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000, 1, 0, 1);
    issue("or stall",   5'b00111, 16'h1200, 16'h0034, 16'h1234, 5'b00000, 1, 5, 1);
    issue("nor",        5'b01000, 16'h00FF, 16'hFF00, 16'h0000, 5'b01000, 1, 0, 1);
    issue("xor",        5'b01010, 16'hA5A5, 16'h0F0F, 16'hAAAA, 5'b10000, 1, 0, 1);
    issue("not",        5'b01100, 16'h0000, 16'h5555, 16'hFFFF, 5'b10000, 1, 0, 1);
    issue("mull s",     5'b01111, 16'hFFFD, 16'h0005, 16'hFFF1, 5'b10000, 17, 0, 1);
    issue("mulh s",     5'b00011, 16'hFFFD, 16'h0005, 16'hFFFF, 5'b10000, 17, 0, 1);
    issue("mulh s min", 5'b00011, 16'h8000, 16'h8000, 16'h4000, 5'b00100, 17, 0, 1);
    issue("mulh u",     5'b00100, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b10100, 17, 0, 1);
    issue("mull u",     5'b10000, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b00100, 17, 2, 1);
    issue("udiv",       5'b01101, 16'd100,  16'd7,    16'd14,   5'b00000, 17, 0, 1);
    issue("urem",       5'b01110, 16'd100,  16'd7,    16'd2,    5'b00000, 17, 0, 1);
    issue("udiv by 0",  5'b01101, 16'h1234, 16'h0000, 16'hFFFF, 5'b10100, 17, 0, 1);
    issue("urem by 0",  5'b01110, 16'h1234, 16'h0000, 16'h1234, 5'b00100, 17, 0, 1);
    issue("lsl 1",      5'b11001, 16'h8001, 16'd1,    16'h0002, 5'b00010, 1, 0, 1);
    issue("lsl 17",     5'b11001, 16'h0001, 16'd17,   16'h0000, 5'b01000, 1, 0, 1);
    issue("lsr 1",      5'b11000, 16'h0003, 16'd1,    16'h0001, 5'b00010, 1, 0, 1);
    issue("asr 4",      5'b11010, 16'hF0F0, 16'd4,    16'hFF0F, 5'b10000, 1, 0, 1);
    issue("asr 20",     5'b11010, 16'h8000, 16'd20,   16'hFFFF, 5'b10010, 1, 0, 1);
    issue("ror 1",      5'b11100, 16'h0001, 16'd1,    16'h8000, 5'b10010, 1, 0, 1);
    issue("ror 0",      5'b11100, 16'h1234, 16'd0,    16'h1234, 5'b00000, 1, 0, 1);
    issue("ror 20",     5'b11100, 16'h000F, 16'd20,   16'hF000, 5'b10010, 1, 0, 1);
    issue("illegal",    5'b10001, 16'h1234, 16'h5678, 16'h0000, 5'b01001, 1, 0, 1);
    drain();

    // Reset in the middle of a multiply: the operation must vanish
    issue("mul abort",  5'b10000, 16'h0003, 16'h0005, 16'h000F, 5'b00000, 17, 0, 0);
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async rst in_ready", {31'b0, alu.in_ready}, 32'd1);
    chk("async rst out_valid", {31'b0, alu.out_valid}, 32'd0);
    chk("async rst r", {16'b0, alu.r}, 32'd0);
    chk("async rst flags", {27'b0, alu.negative, alu.zero, alu.overflow, alu.cout, alu.illegal},
        32'd0);
    @(negedge clk); #1 rst = 1'b0;
    seen_v = 0;
    repeat (25) begin
      @(negedge clk);
      if (alu.out_valid) seen_v++;
    end
    chk("aborted op silent", seen_v, 0);
    issue("add after rst", 5'b00001, 16'h0002, 16'h0003, 16'h0005, 5'b00000, 1, 0, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
